noc_fi_status_tx: RTL and testbench
===================================

Name: noc_fi_status_tx

Overview:
- Transmit side of the NoC fault-injection control path: reports the active per-node fault-injection link masks back to the host as DII packets.
- Watches the fim_en vector driven by the control module's FI decoder. When a node's mask changes, or the host asks for a full dump, it emits one 4-flit status packet per affected node.
- Output goes onto the control module's DII egress, using the valid/ready handshake.

Parameters:
- X, 3, mesh width.
- Y, 3, mesh height.
- NODES, X*Y (localparam), node count; must be ≤ 256.
- HOST_ID, 16'h0000, DII destination written in flit 0.
- STATUS_TYPE, 16'h4649, type/flags word written in flit 2.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- fim_en  in  NODES×8  current per-node FI link-enable masks.
- debug_id  in  16  own DII address, written in flit 1.
- report_all  in  1  single-cycle pulse; queue a report for every node.
- flit_out  out  dii_flit  packet flits (valid, last, data[15:0]).
- flit_out_ready  in  1  downstream accepts flit_out this cycle.
- busy  out  1  high when any report is pending or in flight.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - flit_out.valid=0, last=0, data=0; busy=0.
  - pending=0, snap=0, rr_ptr=0; FSM in IDLE.
- Change detection:
  - snap registers fim_en every cycle.
  - When fim_en[i] != snap[i], pending[i] is set on the next edge.
  - report_all sets all pending bits.
  - Set always wins over a same-cycle clear.
- Selection:
  - In IDLE with pending!=0, pick the first set index at or after rr_ptr, wrapping modulo NODES.
  - Latch sel_node and sel_mask=fim_en[sel_node].
  - Clear pending[sel_node].
  - Set rr_ptr = sel_node+1, wrapping NODES-1 → 0.
  - Go to DEST. Selection takes one cycle, so the first flit is valid on the cycle after pending is observed.
- FSM states: IDLE → DEST → SRC → TYPE → PAYLOAD → IDLE.
  - DEST: data=HOST_ID, last=0.
  - SRC: data=debug_id, last=0.
  - TYPE: data=STATUS_TYPE, last=0.
  - PAYLOAD: data={sel_node[7:0], sel_mask}, last=1.
- Handshake:
  - valid=1 in all states except IDLE.
  - Advance only on valid && flit_out_ready.
  - While not ready, data and last stay stable; valid never drops mid-packet.
- Payload and back-to-back packets:
  - The payload carries the mask latched at selection.
  - A change to that node during transmission re-sets its pending bit, so the node is reported again afterwards.
  - On PAYLOAD accept with pending still !=0, select in the same cycle and go straight to DEST. There are no idle bubbles between packets.
- busy = (state != IDLE) || (pending != 0).
- Reset mid-packet: the packet is abandoned with valid=0 immediately. No resend after reset; fim_en also resets to 0, so no spurious report follows.

Decomposition:
- dii_package provides the dii_flit typedef.
- Shared package noc_fi_pkg (used by this block and the FI decoder) holds:
  - the fi_state_t enum;
  - FI_STATUS_TYPE;
  - the payload field positions, node [15:8] and links [7:0].
- One sub-module: noc_fi_rr_pick, a combinational round-robin first-set finder (pending, rr_ptr → valid, index).

Test Plan:
1. After reset with ready=1, set fim_en[4]=8'h05 → 4 flits: 0000, debug_id, 4649, 0405 (last=1 on the 4th). busy falls the cycle after the 4th accept.
2. Pulse report_all with fim_en all zero, NODES=9, ready=1 → 9 back-to-back packets, payloads 0000, 0100 … 0800. There is no idle cycle between packets.
3. Hold ready=0 for 5 cycles during SRC → data stays debug_id and valid stays 1 throughout. The sequence resumes on ready=1.
4. Change fim_en[2] to 8'h01, then to 8'h03 during its TYPE flit → the first packet carries 0201, and a second packet carries 0203.
5. With rr_ptr=5, set changes on nodes 1 and 7 in the same cycle → node 7 is reported first, then node 1 after wrap.
6. Assert rst_n=0 mid-PAYLOAD → valid=0 asynchronously. After release, no flits appear until fim_en changes.

Source files
------------

// File: rtl/dii_package.sv
// -----------------------------------------------------------------------------
// dii_package
// Flit type used on the debug interconnect (DII) control-module egress.
//   valid : flit present this cycle
//   last  : final flit of a packet
//   data  : 16-bit flit payload
// -----------------------------------------------------------------------------
package dii_package;

    typedef struct packed {
        logic        valid;
        logic        last;
        logic [15:0] data;
    } dii_flit;

endpackage

// File: rtl/noc_fi_pkg.sv
// -----------------------------------------------------------------------------
// noc_fi_pkg
// Definitions shared by the NoC fault-injection decoder and the status
// transmitter: the packet FSM state type, the status type word and the
// layout of the status payload flit (node index high byte, link mask low byte).
// -----------------------------------------------------------------------------
package noc_fi_pkg;

    typedef enum logic [2:0] {
        FI_IDLE    = 3'd0,
        FI_DEST    = 3'd1,
        FI_SRC     = 3'd2,
        FI_TYPE    = 3'd3,
        FI_PAYLOAD = 3'd4
    } fi_state_t;

    localparam logic [15:0] FI_STATUS_TYPE = 16'h4649;

    localparam int FI_PL_NODE_MSB = 15;
    localparam int FI_PL_NODE_LSB = 8;
    localparam int FI_PL_LINK_MSB = 7;
    localparam int FI_PL_LINK_LSB = 0;

    // Build the payload flit from a node index and its link mask.
    function automatic logic [15:0] fi_payload(input logic [7:0] node,
                                               input logic [7:0] links);
        logic [15:0] p;
        p = '0;
        p[FI_PL_NODE_MSB:FI_PL_NODE_LSB] = node;
        p[FI_PL_LINK_MSB:FI_PL_LINK_LSB] = links;
        return p;
    endfunction

endpackage

// File: rtl/noc_fi_rr_pick.sv
// -----------------------------------------------------------------------------
// noc_fi_rr_pick
// Combinational round-robin first-set finder.
//   pending : request vector, one bit per node
//   rr_ptr  : search start index (always < NODES)
//   valid   : at least one pending bit is set
//   index   : first set index at or after rr_ptr, wrapping modulo NODES
// -----------------------------------------------------------------------------
module noc_fi_rr_pick #(
    parameter int NODES = 9,
    parameter int IDXW  = 4
) (
    input  logic [NODES-1:0] pending,
    input  logic [IDXW-1:0]  rr_ptr,
    output logic             valid,
    output logic [IDXW-1:0]  index
);

    function automatic logic [IDXW-1:0] wrap_add(input logic [IDXW-1:0] base,
                                                 input int off);
        int s;
        s = int'(base) + off;
        if (s >= NODES) s = s - NODES;
        return IDXW'(s);
    endfunction

    // Scan from the farthest offset down so the nearest set bit is the last
    // assignment and therefore wins.
    always_comb begin
        valid = 1'b0;
        index = '0;
        for (int k = NODES - 1; k >= 0; k--) begin
            if (pending[wrap_add(rr_ptr, k)]) begin
                valid = 1'b1;
                index = wrap_add(rr_ptr, k);
            end
        end
    end

endmodule

// File: rtl/noc_fi_status_tx.sv
// -----------------------------------------------------------------------------
// noc_fi_status_tx
// Reports per-node fault-injection link masks to the host as 4-flit DII
// packets (HOST_ID, debug_id, STATUS_TYPE, {node, mask}). A packet is queued
// for a node whenever its mask changes, or for every node on report_all.
// Handshake: a flit transfers on a cycle where flit_out.valid and
// flit_out_ready are both high; once valid rises it stays high with data and
// last unchanged until the packet's final flit is accepted.
//   clk, rst_n      : clock, asynchronous active-low reset
//   fim_en          : current per-node link-enable masks
//   debug_id        : own DII address (flit 1)
//   report_all      : one-cycle pulse, queue a report for every node
//   flit_out        : registered egress flit
//   flit_out_ready  : downstream accepts flit_out
//   busy            : report pending or in flight
//   state_dbg       : packet FSM state
// -----------------------------------------------------------------------------
module noc_fi_status_tx
    import dii_package::*;
    import noc_fi_pkg::*;
#(
    parameter int          X           = 3,
    parameter int          Y           = 3,
    parameter logic [15:0] HOST_ID     = 16'h0000,
    parameter logic [15:0] STATUS_TYPE = FI_STATUS_TYPE,
    localparam int         NODES       = X * Y
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NODES-1:0][7:0] fim_en,
    input  logic [15:0]           debug_id,
    input  logic                  report_all,
    output dii_flit               flit_out,
    input  logic                  flit_out_ready,
    output logic                  busy,
    output fi_state_t             state_dbg
);

    localparam int IDXW = (NODES > 1) ? $clog2(NODES) : 1;

    fi_state_t             state_q, state_d;
    dii_flit               flit_q, flit_d;
    logic [NODES-1:0][7:0] snap_q, snap_d;
    logic [NODES-1:0]      pending_q, pending_d, set_vec, clr_vec;
    logic [IDXW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [IDXW-1:0]       sel_node_q, sel_node_d;
    logic [7:0]            sel_mask_q, sel_mask_d;
    logic [IDXW-1:0]       pick_idx;
    logic                  pick_valid, accept, take;

    noc_fi_rr_pick #(
        .NODES (NODES),
        .IDXW  (IDXW)
    ) u_pick (
        .pending (pending_q),
        .rr_ptr  (rr_ptr_q),
        .valid   (pick_valid),
        .index   (pick_idx)
    );

    assign snap_d = fim_en;
    assign accept = flit_q.valid & flit_out_ready;
    // A new packet starts from IDLE, or directly on the accepted final flit
    // so consecutive packets leave no idle gap.
    assign take   = pick_valid &
                    ((state_q == FI_IDLE) | ((state_q == FI_PAYLOAD) & accept));

    always_comb begin
        for (int i = 0; i < NODES; i++) begin
            set_vec[i] = (fim_en[i] != snap_q[i]) | report_all;
        end
    end

    always_comb begin
        state_d    = state_q;
        flit_d     = flit_q;
        sel_node_d = sel_node_q;
        sel_mask_d = sel_mask_q;
        rr_ptr_d   = rr_ptr_q;
        clr_vec    = '0;

        case (state_q)
            FI_DEST: if (accept) begin
                state_d = FI_SRC;
                flit_d  = '{valid: 1'b1, last: 1'b0, data: debug_id};
            end
            FI_SRC: if (accept) begin
                state_d = FI_TYPE;
                flit_d  = '{valid: 1'b1, last: 1'b0, data: STATUS_TYPE};
            end
            FI_TYPE: if (accept) begin
                state_d = FI_PAYLOAD;
                flit_d  = '{valid: 1'b1, last: 1'b1,
                            data: fi_payload(8'(sel_node_q), sel_mask_q)};
            end
            FI_PAYLOAD: if (accept) begin
                state_d = FI_IDLE;
                flit_d  = '0;
            end
            default: ;
        endcase

        if (take) begin
            state_d           = FI_DEST;
            flit_d            = '{valid: 1'b1, last: 1'b0, data: HOST_ID};
            sel_node_d        = pick_idx;
            sel_mask_d        = fim_en[pick_idx];
            clr_vec[pick_idx] = 1'b1;
            rr_ptr_d          = (pick_idx == IDXW'(NODES - 1)) ? '0 : pick_idx + 1'b1;
        end

        // A change seen in the same cycle as the clear re-arms the node.
        pending_d = (pending_q & ~clr_vec) | set_vec;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FI_IDLE;
            flit_q     <= '0;
            snap_q     <= '0;
            pending_q  <= '0;
            rr_ptr_q   <= '0;
            sel_node_q <= '0;
            sel_mask_q <= '0;
        end else begin
            state_q    <= state_d;
            flit_q     <= flit_d;
            snap_q     <= snap_d;
            pending_q  <= pending_d;
            rr_ptr_q   <= rr_ptr_d;
            sel_node_q <= sel_node_d;
            sel_mask_q <= sel_mask_d;
        end
    end

    assign flit_out  = flit_q;
    assign busy      = (state_q != FI_IDLE) | (|pending_q);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_noc_fi_status_tx.sv
// Self-checking bench for noc_fi_status_tx (3x3 mesh).
module tb_noc_fi_status_tx;
  import dii_package::*;
  import noc_fi_pkg::*;

  localparam int          NODES    = 9;
  localparam logic [15:0] HOST     = 16'h0000;
  localparam logic [15:0] STAT     = 16'h4649;
  localparam logic [15:0] MY_ID    = 16'hBEEF;

  logic                  clk;
  logic                  rst_n;
  logic [NODES-1:0][7:0] fim_en;
  logic [15:0]           debug_id;
  logic                  report_all;
  dii_flit               flit_out;
  logic                  flit_out_ready;
  logic                  busy;
  fi_state_t             state_dbg;

  int n_checks = 0;
  int n_errors = 0;
  logic [16:0] exp_q[$];

  noc_fi_status_tx dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fim_en         (fim_en),
    .debug_id       (debug_id),
    .report_all     (report_all),
    .flit_out       (flit_out),
    .flit_out_ready (flit_out_ready),
    .busy           (busy),
    .state_dbg      (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard: expected {last, data} per accepted flit
  task automatic push_flit(input logic last, input logic [15:0] data);
    exp_q.push_back({last, data});
  endtask

  task automatic push_pkt(input logic [7:0] node, input logic [7:0] mask);
    push_flit(1'b0, HOST);
    push_flit(1'b0, MY_ID);
    push_flit(1'b0, STAT);
    push_flit(1'b1, {node, mask});
  endtask

  always @(negedge clk) begin
    if (rst_n && flit_out.valid && flit_out_ready) begin
      logic [16:0] e;
      check("exp_q_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("flit", 32'({flit_out.last, flit_out.data}), 32'(e));
      end
    end
  end

  // driver helpers
  task automatic wait_valid(input string tag);
    int n = 0;
    @(negedge clk);
    while (!flit_out.valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, 32'(flit_out.valid), 32'd1);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    check({tag, "_drained"}, exp_q.size(), 32'd0);
    @(negedge clk);
    check({tag, "_busy_low"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic any_valid;
    int n;
    rst_n          = 1'b0;
    fim_en         = '0;
    debug_id       = MY_ID;
    report_all     = 1'b0;
    flit_out_ready = 1'b0;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 32'(flit_out.valid), 32'd0);
    check("rst_last",  32'(flit_out.last),  32'd0);
    check("rst_data",  32'(flit_out.data),  32'd0);
    check("rst_busy",  32'(busy),           32'd0);
    check("rst_state", 32'(state_dbg),      32'd0);
    rst_n = 1'b1;
    flit_out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_valid", 32'(flit_out.valid), 32'd0);
    check("idle_busy",  32'(busy),           32'd0);

    // report_all: nine back-to-back packets from node 0
    @(posedge clk); #1;
    report_all = 1'b1;
    for (int i = 0; i < NODES; i++) push_pkt(8'(i), 8'h00);
    @(posedge clk); #1;
    report_all = 1'b0;
    wait_valid("t2");
    check("t2_no_bubble", 32'(flit_out.valid), 32'd1);
    for (int i = 1; i < 4 * NODES; i++) begin
      @(negedge clk);
      check("t2_no_bubble", 32'(flit_out.valid), 32'd1);
    end
    drain("t2");

    // single change on node 4, with first-flit latency
    @(posedge clk); #1;
    fim_en[4] = 8'h05;
    push_pkt(8'd4, 8'h05);
    @(negedge clk);
    @(negedge clk);
    check("t1_valid_pre", 32'(flit_out.valid), 32'd0);
    check("t1_busy_pend", 32'(busy),           32'd1);
    @(negedge clk);
    check("t1_valid_first", 32'(flit_out.valid), 32'd1);
    drain("t1");

    // rr_ptr is now 5: nodes 1 and 7 change together, 7 goes first
    @(posedge clk); #1;
    fim_en[1] = 8'h11;
    fim_en[7] = 8'h77;
    push_pkt(8'd7, 8'h77);
    push_pkt(8'd1, 8'h11);
    drain("t5");

    // node 2 changes again while its TYPE flit is on the wire
    @(posedge clk); #1;
    fim_en[2] = 8'h01;
    push_pkt(8'd2, 8'h01);
    n = 0;
    @(negedge clk);
    while (!(flit_out.valid && flit_out.data == STAT) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t4_type_seen", 32'(flit_out.data), 32'(STAT));
    fim_en[2] = 8'h03;
    push_pkt(8'd2, 8'h03);
    drain("t4");

    // back-pressure held during SRC
    @(posedge clk); #1;
    flit_out_ready = 1'b0;
    fim_en[0] = 8'h5A;
    push_pkt(8'd0, 8'h5A);
    wait_valid("t3");
    @(posedge clk); #1;
    flit_out_ready = 1'b1;
    @(posedge clk); #1;
    flit_out_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("t3_hold_valid", 32'(flit_out.valid), 32'd1);
      check("t3_hold_data",  32'(flit_out.data),  32'(MY_ID));
      check("t3_hold_last",  32'(flit_out.last),  32'd0);
    end
    @(posedge clk); #1;
    flit_out_ready = 1'b1;
    drain("t3");

    // reset during PAYLOAD
    @(posedge clk); #1;
    flit_out_ready = 1'b0;
    fim_en[3] = 8'h33;
    push_flit(1'b0, HOST);
    push_flit(1'b0, MY_ID);
    push_flit(1'b0, STAT);
    wait_valid("t6");
    @(posedge clk); #1;
    flit_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    flit_out_ready = 1'b0;
    @(negedge clk);
    check("t6_pl_valid", 32'(flit_out.valid), 32'd1);
    check("t6_pl_last",  32'(flit_out.last),  32'd1);
    check("t6_pl_data",  32'(flit_out.data),  32'h0333);
    check("t6_sb_empty", exp_q.size(),        32'd0);
    #2;
    rst_n  = 1'b0;
    fim_en = '0;
    #1;
    check("t6_async_valid", 32'(flit_out.valid), 32'd0);
    check("t6_async_busy",  32'(busy),           32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    flit_out_ready = 1'b1;
    any_valid = 1'b0;
    repeat (20) begin
      @(negedge clk);
      any_valid = any_valid | flit_out.valid;
    end
    check("t6_no_resend", 32'(any_valid), 32'd0);
    check("t6_idle_busy", 32'(busy),      32'd0);
    @(posedge clk); #1;
    fim_en[6] = 8'h66;
    push_pkt(8'd6, 8'h66);
    drain("t6_after");

    check("final_sb_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
